// File: rtl/diagcard_code_sequencer.sv
// POST-code display sequencer: sync-toggle capture, show-ahead FIFO, minimum hold, 2-digit 7-seg scan.
// Optional build macro DIAGCARD_DROP_DUP_EN discards pushes that repeat the last accepted code.
module diagcard_code_sequencer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 3300000,
  parameter int SCAN_DIV    = 16384
) (
  input  logic                     lpc_clk,
  input  logic                     lpc_rst,
  input  logic [7:0]               code,
  input  logic                     code_sync,
  input  logic                     clr_ovf,
  output logic [7:0]               disp_code,
  output logic                     disp_valid,
  output logic [6:0]               seg,
  output logic [1:0]               dig_en,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [6:0]    DASH      = 7'b1000000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic [SW-1:0] scnt;
  logic          sync_prev;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic       push, dup, full, empty, pop, wr_en, ovf_set, hold_done, scan_wrap;
  logic [7:0] head, disp_nxt;
  logic       valid_nxt;
  logic [1:0] dig_nxt;
  logic [3:0] nib;

  // {g,f,e,d,c,b,a}, lowercase b and d
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b0111111;
      4'h1: hex_glyph = 7'b0000110;
      4'h2: hex_glyph = 7'b1011011;
      4'h3: hex_glyph = 7'b1001111;
      4'h4: hex_glyph = 7'b1100110;
      4'h5: hex_glyph = 7'b1101101;
      4'h6: hex_glyph = 7'b1111101;
      4'h7: hex_glyph = 7'b0000111;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1101111;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b1111100;
      4'hC: hex_glyph = 7'b0111001;
      4'hD: hex_glyph = 7'b1011110;
      4'hE: hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

`ifdef DIAGCARD_DROP_DUP_EN
  logic [7:0] last_code;

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) last_code <= 8'hFF;
    else if (wr_en) last_code <= code;
  end

  assign dup = (code == last_code);
`else
  assign dup = 1'b0;
`endif

  assign push      = (code_sync != sync_prev);
  assign full      = (fifo_level == FULL_LVL);
  assign empty     = (fifo_level == '0);
  assign head      = mem[rd_ptr];
  assign hold_done = (hcnt == HOLD_LAST);
  // Popping frees a slot on the same edge, so a full FIFO can still accept
  assign pop       = !empty && ((state == IDLE) || (state == DONE) ||
                                ((state == SHOW) && hold_done));
  assign wr_en     = push && !dup && (!full || pop);
  assign ovf_set   = push && !dup && full && !pop;

  assign disp_nxt  = pop ? head : disp_code;
  assign valid_nxt = disp_valid | pop;
  assign scan_wrap = (scnt == SCAN_LAST);
  assign dig_nxt   = scan_wrap ? {dig_en[0], dig_en[1]} : dig_en;
  assign nib       = dig_nxt[1] ? disp_nxt[7:4] : disp_nxt[3:0];

  always_ff @(posedge lpc_clk) begin
    if (wr_en) mem[wr_ptr] <= code;
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      sync_prev  <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      sync_prev <= code_sync;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      disp_code  <= 8'h00;
      disp_valid <= 1'b0;
    end else begin
      disp_code  <= disp_nxt;
      disp_valid <= valid_nxt;
      if (pop) begin
        hcnt  <= '0;
        state <= SHOW;
      end else if (state == SHOW) begin
        if (hold_done) state <= DONE;
        else           hcnt  <= hcnt + HW'(1);
      end else if (state != IDLE && state != DONE) begin
        state <= IDLE;
      end
    end
  end

  // seg is built from next-cycle digit and code so it stays aligned with dig_en
  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      scnt   <= '0;
      dig_en <= 2'b01;
      seg    <= DASH;
    end else begin
      scnt   <= scan_wrap ? '0 : scnt + SW'(1);
      dig_en <= dig_nxt;
      seg    <= valid_nxt ? hex_glyph(nib) : DASH;
    end
  end

endmodule
